// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared pipeline types for the skid stage
// Purpose: stage occupancy state encoding and the if/id payload bundle.
// Ports: none (package).
package pipe_stage_skid_pkg;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } if_id_t;

   localparam int IF_ID_WIDTH = $bits(if_id_t);

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - WIDTH-wide load/clear payload register
// Purpose: one storage slot of the pipeline stage.
// Ports: clk, reset_n (async active-low), load (capture d), clear (zero q),
//        d (payload in), q (payload out).
module pipe_entry #(
   parameter int WIDTH = 96,
   parameter bit CLEAR = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (CLEAR) begin : g_clear
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               q <= '0;
            end else if (clear) begin
               q <= '0;
            end else if (load) begin
               q <= d;
            end
         end
      end else begin : g_keep
         // Payload is don't-care while empty, so no reset or clear is spent on it.
         logic unused_reset;
         assign unused_reset = reset_n;
         always_ff @(posedge clk) begin
            if (load && !clear) begin
               q <= d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with optional skid entry
// Purpose: one-cycle-latency register slice between two pipeline stages.
// Ports: clk, reset_n (async active-low), flush (drop all entries),
//        s_valid/s_ready/s_data (upstream), m_valid/m_ready/m_data (downstream),
//        occupancy (entries held, 0..2).
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int WIDTH      = IF_ID_WIDTH,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       occupancy
);

   stage_state_e     state_q, state_d;
   logic             s_ready_q;
   logic             accept, drain;
   logic             main_load, main_clear, main_from_skid, skid_load;
   logic [WIDTH-1:0] main_q, main_d, skid_q;

   assign m_valid   = (state_q != ST_EMPTY);
   assign m_data    = main_q;
   assign occupancy = state_q;
   // Skid variant: registered ready breaks the m_ready -> s_ready path.
   assign s_ready   = (SKID != 0) ? s_ready_q : (!m_valid || m_ready);
   assign accept    = s_valid && s_ready;
   assign drain     = m_valid && m_ready;
   assign main_d    = main_from_skid ? skid_q : s_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_EMPTY;
         s_ready_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d != ST_TWO);
      end
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         state_d    = ST_EMPTY;
         main_clear = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_load = 1'b1;
               end else if (accept && SKID != 0) begin
                  // Downstream stalled: park the new payload behind the head.
                  skid_load = 1'b1;
                  state_d   = ST_TWO;
               end else if (drain) begin
                  main_clear = 1'b1;
                  state_d    = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   pipe_entry #(.WIDTH(WIDTH), .CLEAR(CLEAR_DATA != 0)) u_main (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (main_load),
      .clear   (main_clear),
      .d       (main_d),
      .q       (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_entry #(.WIDTH(WIDTH), .CLEAR(CLEAR_DATA != 0)) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (skid_load),
            .clear   (flush),
            .d       (s_data),
            .q       (skid_q)
         );
      end else begin : g_no_skid
         logic unused_skid;
         assign unused_skid = skid_load;
         assign skid_q      = '0;
      end
   endgenerate

endmodule
